cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Shares one `cordic_pipeline` instance (Q16.16 angle in, Q16.16 cos/sin out, fixed latency, no valid or stall) among `N_REQ` requesters. The block:
- picks requests with round-robin arbitration;
- folds each angle into the CORDIC convergence range;
- tracks requester ID and fold flag alongside the pipeline;
- returns results through a credit-protected response FIFO with valid/ready.

It sits between the angle-producing clients and the CORDIC datapath.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `LATENCY`, 16, cycles from `cdc_angle` change to matching `cdc_cos`/`cdc_sin`
- `FIFO_DEPTH`, 32, response FIFO entries, power of two, ≥ `LATENCY`+1
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in `N_REQ`: per-requester request valid
- `req_ready` out `N_REQ`: per-requester grant, one-hot or zero
- `req_angle` in 32*`N_REQ`: signed Q16.16 radians in [-π, π); requester k uses bits [32k+31:32k]
- `cdc_angle` out 32: registered angle to the pipeline
- `cdc_cos`, `cdc_sin` in 32: pipeline outputs
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts the response
- `rsp_id` out clog2(`N_REQ`): originating requester
- `rsp_cos`, `rsp_sin` out 32: signed Q16.16 results

## Operation
- **Credits:** `inflight` counts valid tags in the shift register; `fcount` is FIFO occupancy.
  - Issue is allowed only when `inflight` + `fcount` < `FIFO_DEPTH`, so the FIFO can never overflow.
- **Arbitration:** combinational round-robin starting at pointer `rr`.
  - `req_ready[k]`=1 only for the first k with `req_valid[k]`, and only when issue is allowed.
  - A transfer is `req_valid[k]` & `req_ready[k]`.
  - After a transfer, `rr` ← k+1 mod `N_REQ`. With no transfer, `rr` holds.
- **Fold (per accepted angle a), using `HALF_PI`=102944 and `PI`=205887:**
  - a > `HALF_PI`: issue a−`PI`, neg=1.
  - a < −`HALF_PI`: issue a+`PI`, neg=1.
  - Otherwise issue a, neg=0.
  - Compare and subtract are 32-bit signed; no overflow is possible in range.
- **Tag shift register:** `LATENCY` stages of {v, id, neg}. Stage 0 is loaded with {transfer, k, neg} in the same edge that loads `cdc_angle`.
- **Drain:** when the last stage has v=1, the FIFO is written with {id, neg ? −`cdc_cos` : `cdc_cos`, neg ? −`cdc_sin` : `cdc_sin`}.
  - Negation is two's complement, 32-bit.
- **Response:** `rsp_valid` = FIFO non-empty. Outputs show the FIFO head. Pop on `rsp_valid` & `rsp_ready`.
- **Idle:** with no transfer, `cdc_angle` holds its value and stage 0 v=0.
- Pipeline outputs are ignored whenever the last-stage v=0.

## Timing
- **Reset:** `rr`=0, all tag v=0, FIFO empty, `inflight`=0, `cdc_angle`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_cos`/`rsp_sin`=0. `req_ready` is combinational and is 0 only while no request is valid.
- **Reset mid-operation:** in-flight and queued results are discarded. The pipeline is not reset, but its garbage is masked by the cleared tags.
- **Throughput and latency:**
  - One issue per cycle.
  - A request accepted at edge E0 drives `cdc_angle` from E0.
  - Its result is written to the FIFO at edge E0+`LATENCY`+1; `rsp_valid` rises after that edge.
  - Minimum latency is `LATENCY`+1 cycles.
- **Ordering:** responses leave in issue order.
- **Simultaneous FIFO write and read:** `fcount` is unchanged.
- **Full credit:** all `req_ready`=0. A pop in a cycle frees one credit in the next cycle, not the same one.
- **`rsp_ready` held low:** once `inflight`+`fcount` reaches `FIFO_DEPTH`, issue stops. No result is lost.

## Structure
- Package `cordic_pkg`:
  - `Q_W`=32, `FRAC_W`=16
  - `PI_Q16`=205887, `HALF_PI_Q16`=102944
  - `CORDIC_LATENCY`=16
  - tag struct {v, id, neg}
- Sub-module `cordic_rsp_fifo`: synchronous FIFO, async active-low reset, with count output.
- Arbiter, fold, tag shift register and credit counter stay in `cordic_arbiter`.

## Test plan
All value checks allow ±16 LSB tolerance on cos/sin.
- **Single request:** requester 0 sends 30° (34314) → after `LATENCY`+1 cycles, `rsp_id`=0, cos≈56756, sin≈32768.
- **Fold:** 150° (171572) → issued −34315, neg=1 → cos≈−56756, sin≈+32768. Also −150° → cos≈−56756, sin≈−32768.
- **Round-robin:** all 4 requesters valid every cycle for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses carry IDs in that order, back-to-back.
- **Backpressure:** `rsp_ready`=0 with continuous requests → exactly `FIFO_DEPTH` accepts, then `req_ready`=0. Releasing `rsp_ready` drains all 32 results with no loss or reordering.
- **Reset mid-flight:** assert `rst_n`=0 with 10 results in flight → after release, `rsp_valid` stays 0 for ≥ `LATENCY`+2 cycles with no new requests.
- **Boundaries:** ±90° (±102943) are not folded; −180° (−205887) folds to 0 → cos≈−65536, sin≈0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the CORDIC request arbiter.
// Angles and results are signed Q16.16 radians / unit values.
package cordic_pkg;

  localparam int Q_W            = 32;
  localparam int FRAC_W         = 16;
  localparam int CORDIC_LATENCY = 16;
  localparam int ID_W           = 3;

  localparam logic signed [Q_W-1:0] PI_Q16      = 32'sd205887;
  localparam logic signed [Q_W-1:0] HALF_PI_Q16 = 32'sd102944;

  // Travels alongside the CORDIC pipeline to mark which results are real.
  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            neg;
  } tag_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; storage is not reset.
// Writes are never issued while full because the arbiter holds credits.
module cordic_rsp_fifo #(
  parameter int DATA_W = 67,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_rd;

  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one fixed-latency CORDIC pipeline among N_REQ
// requesters: folds angles, tags them through the pipeline, queues results.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LATENCY    = CORDIC_LATENCY,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [Q_W*N_REQ-1:0]      req_angle,
  output logic signed [Q_W-1:0]     cdc_angle,
  input  logic signed [Q_W-1:0]     cdc_cos,
  input  logic signed [Q_W-1:0]     cdc_sin,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic signed [Q_W-1:0]     rsp_cos,
  output logic signed [Q_W-1:0]     rsp_sin
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FW  = ID_W + 2 * Q_W;

  // Bring the angle into [-pi/2, pi/2]; the top bit flags a half-turn shift.
  function automatic logic [Q_W:0] fold_angle(input logic signed [Q_W-1:0] a);
    if (a > HALF_PI_Q16)       return {1'b1, a - PI_Q16};
    else if (a < -HALF_PI_Q16) return {1'b1, a + PI_Q16};
    return {1'b0, a};
  endfunction

  function automatic logic signed [Q_W-1:0] cond_negate(input logic signed [Q_W-1:0] x,
                                                        input logic en);
    return en ? -x : x;
  endfunction

  logic signed [Q_W-1:0] angle_arr [N_REQ];
  logic [IDW-1:0]        rr;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_found;
  logic                  credit_ok;
  logic                  xfer;
  logic [Q_W:0]          fold_w;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fcount;
  tag_t                  tag_p0 [LATENCY];
  tag_t                  drn_p1;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_head;
  logic                  fifo_empty;
  logic [ID_W-1:0]       head_id;
  logic signed [Q_W-1:0] head_cos;
  logic signed [Q_W-1:0] head_sin;

  for (genvar k = 0; k < N_REQ; k++) begin : g_ang
    assign angle_arr[k] = req_angle[Q_W*k +: Q_W];
  end

  assign credit_ok = ({1'b0, inflight} + {1'b0, fcount}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    logic [IDW:0] sum;
    sum       = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      if (!gnt_found && req_valid[sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[IDW-1:0];
      end
    end
    if (gnt_found && credit_ok) req_ready[gnt_idx] = 1'b1;
  end

  assign xfer   = gnt_found && credit_ok;
  assign fold_w = fold_angle(angle_arr[gnt_idx]);

  // p0: issue to the pipeline and shift tags; p1: tag aligned with cdc_cos/cdc_sin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= '0;
      cdc_angle <= '0;
      for (int i = 0; i < LATENCY; i++) tag_p0[i] <= '0;
      drn_p1    <= '0;
      inflight  <= '0;
    end else begin
      if (xfer) begin
        rr        <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cdc_angle <= signed'(fold_w[Q_W-1:0]);
      end
      tag_p0[0] <= '{v: xfer, id: ID_W'(gnt_idx), neg: fold_w[Q_W]};
      for (int i = 1; i < LATENCY; i++) tag_p0[i] <= tag_p0[i-1];
      drn_p1 <= tag_p0[LATENCY-1];
      case ({xfer, drn_p1.v})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign fifo_wdata = {drn_p1.id,
                       cond_negate(cdc_cos, drn_p1.neg),
                       cond_negate(cdc_sin, drn_p1.neg)};

  cordic_rsp_fifo #(
    .DATA_W (FW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (drn_p1.v),
    .wr_data (fifo_wdata),
    .rd_en   (rsp_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fcount)
  );

  assign head_id  = fifo_head[FW-1 -: ID_W];
  assign head_cos = fifo_head[2*Q_W-1 -: Q_W];
  assign head_sin = fifo_head[Q_W-1:0];

  // Outputs read as zero while empty so uninitialised storage never shows.
  assign rsp_valid = !fifo_empty;
  assign rsp_id    = rsp_valid ? IDW'(head_id) : '0;
  assign rsp_cos   = rsp_valid ? head_cos : '0;
  assign rsp_sin   = rsp_valid ? head_sin : '0;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a behavioural fixed-latency CORDIC.
`timescale 1ns/1ps
module tb_cordic_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 16;
  localparam int DEPTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [32*N_REQ-1:0]   req_angle;
  logic signed [31:0]    cdc_angle;
  logic signed [31:0]    cdc_cos;
  logic signed [31:0]    cdc_sin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic signed [31:0]    rsp_cos;
  logic signed [31:0]    rsp_sin;

  typedef struct { int id; int c; int s; } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   issued_cnt = 0;
  int   popped_cnt = 0;
  int   pops = 0;
  int   dut_xfers = 0;
  int   brr = 0;
  bit   pop_pend = 1'b0;

  cordic_arbiter #(.N_REQ(N_REQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_angle (req_angle),
    .cdc_angle (cdc_angle),
    .cdc_cos   (cdc_cos),
    .cdc_sin   (cdc_sin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cos   (rsp_cos),
    .rsp_sin   (rsp_sin)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared pipeline: LAT register stages, no reset.
  int pc [LAT];
  int ps [LAT];

  function automatic int qtrig(input logic signed [31:0] a, input bit is_sin);
    real r, v;
    r = $itor(a) / 65536.0;
    v = (is_sin ? $sin(r) : $cos(r)) * 65536.0;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  always @(posedge clk) begin
    pc[0] <= qtrig(cdc_angle, 1'b0);
    ps[0] <= qtrig(cdc_angle, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      pc[i] <= pc[i-1];
      ps[i] <= ps[i-1];
    end
  end

  assign cdc_cos = pc[LAT-1];
  assign cdc_sin = ps[LAT-1];

  // Hand-computed Q16.16 results for every angle the stimulus uses.
  function automatic void exp_of(input int a, output int c, output int s);
    case (a)
      34314:   begin c = 56756;  s = 32768;  end
      171572:  begin c = -56756; s = 32768;  end
      -171572: begin c = -56756; s = -32768; end
      0:       begin c = 65536;  s = 0;      end
      102943:  begin c = 0;      s = 65536;  end
      -102943: begin c = 0;      s = -65536; end
      -205887: begin c = -65536; s = 0;      end
      default: begin c = 999999; s = 999999; end
    endcase
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic signed [31:0] act, input int exp);
    int d;
    checks++;
    d = int'(act) - exp;
    if (d < 0) d = -d;
    if ($isunknown(act) || d > 16) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d +/-16", name, act, exp);
    end
  endtask

  // Issue side: predict the grant, check req_ready, push the expected response.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    int g, k, c, s;
    exp_t e;
    if (rst_n === 1'b1) begin
      exp_rdy = '0;
      g = -1;
      if (issued_cnt - popped_cnt < DEPTH) begin
        for (int i = 0; i < N_REQ; i++) begin
          k = (brr + i) % N_REQ;
          if (g < 0 && req_valid[k]) g = k;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          dut_xfers++;
        end
      end
      if (g >= 0) begin
        exp_of(int'($signed(req_angle[32*g +: 32])), c, s);
        e.id = g; e.c = c; e.s = s;
        sb.push_back(e);
        issued_cnt++;
        brr = (g + 1) % N_REQ;
      end
    end
  end

  // Response side: pop and compare whenever the DUT hands over a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got response id %0d, required no response", rsp_id);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk_tol("rsp_cos", rsp_cos, e.c);
        chk_tol("rsp_sin", rsp_sin, e.s);
      end
      pops++;
      pop_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (pop_pend) begin
      popped_cnt++;
      pop_pend = 1'b0;
    end
  end

  task automatic set_angle(input int k, input int a);
    req_angle[32*k +: 32] = a;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_ready_%0d: got no grant in 50 cycles, required a grant", k);
    end
  endtask

  task automatic issue(input int k, input int a, input int exp_cdc);
    set_angle(k, a);
    req_valid[k] = 1'b1;
    wait_ready(k);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    chk("cdc_angle", cdc_angle, exp_cdc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending responses, required 0", name, sb.size());
    end
  endtask

  initial begin
    int n, base, pbase;
    rst_n     = 1'b0;
    req_valid = '0;
    req_angle = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cos", rsp_cos, 0);
    chk("rst_rsp_sin", rsp_sin, 0);
    chk("rst_cdc_angle", cdc_angle, 0);
    chk("rst_req_ready_idle", req_ready, 0);
    req_valid = 4'b0100;
    #1;
    chk("rst_req_ready_comb", req_ready, 4'b0100);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request and its latency
    set_angle(0, 34314);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("single_cdc_angle", cdc_angle, 34314);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("single_latency", n, LAT + 1);
    wait_drain("single");

    // folding and the +/-90 / -180 boundaries
    issue(1, 171572, -34315);
    issue(2, -171572, 34315);
    issue(3, 102943, 102943);
    issue(3, -102943, -102943);
    issue(3, -205887, 0);
    wait_drain("fold");

    // round-robin with everyone requesting
    grant_log.delete();
    set_angle(0, 34314);
    set_angle(1, 171572);
    set_angle(2, -171572);
    set_angle(3, 0);
    req_valid = '1;
    repeat (8) @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) chk("rr_grant_order", grant_log[i], i % N_REQ);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (rsp_valid && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("rr_back_to_back", n, 8);
    wait_drain("rr");

    // backpressure: credits must stop issue at exactly DEPTH
    rsp_ready = 1'b0;
    base  = dut_xfers;
    pbase = pops;
    req_valid = '1;
    repeat (60) @(posedge clk);
    #1;
    chk("bp_accepts", dut_xfers - base, DEPTH);
    chk("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain("bp");
    chk("bp_pops", pops - pbase, dut_xfers - base);

    // reset with results in flight
    set_angle(0, 34314);
    req_valid = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    sb.delete();
    issued_cnt = 0;
    popped_cnt = 0;
    pop_pend   = 1'b0;
    brr        = 0;
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    n = 0;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) n++;
    end
    chk("midrst_quiet_cycles", n, 0);

    // pointer restarts at requester 0 after reset
    grant_log.delete();
    req_valid = '1;
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("post_rst_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
